// File: rtl/symbol_timing_ctrl.sv
// symbol_timing_ctrl: closes the symbol-timing loop around a Gardner TED.
// Generates the per-symbol strobe, averages the returned errors over a window
// and slips the strobe phase by +/-1 sample when the window sum crosses THRESH.
// An ACQ/TRACK state machine selects the window length and reports lock.
// Optional build macro: SYMTIM_STATS_EN enables the saturating adjust counters.
module symbol_timing_ctrl #(
  parameter int OSF        = 20,
  parameter int WERR       = 18,
  parameter int ACC_W      = 24,
  parameter int AVG_LOG2   = 3,
  parameter int THRESH     = 1024,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en_i,
  input  logic signed [WERR-1:0] e_in_i,
  input  logic                   e_valid_i,
  output logic                   sym_valid_o,
  output logic                   locked_o,
  output logic [1:0]             adj_o,
  output logic [15:0]            adv_cnt_o,
  output logic [15:0]            ret_cnt_o
);

  localparam int CW   = $clog2(OSF);
  localparam int WINW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int LCW  = $clog2(LOCK_CNT + 1);
  localparam int UCW  = $clog2(UNLOCK_CNT + 1);

  localparam logic [CW-1:0]   CNT_LAST = CW'(OSF - 1);
  localparam logic [WINW-1:0] WIN_LAST = WINW'((1 << AVG_LOG2) - 1);
  localparam logic [LCW-1:0]  LOCK_LAST   = LCW'(LOCK_CNT - 1);
  localparam logic [UCW-1:0]  UNLOCK_LAST = UCW'(UNLOCK_CNT - 1);

  localparam logic signed [ACC_W:0]   SMAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   SMIN = -SMAX;
  localparam logic signed [ACC_W-1:0] TH_P = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] TH_N = -TH_P;

  localparam logic [1:0] ADJ_NONE = 2'b00;
  localparam logic [1:0] ADJ_ADV  = 2'b01;
  localparam logic [1:0] ADJ_RET  = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, TRACK = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WINW-1:0]         win_q, win_d;
  logic [1:0]              pend_q, pend_d;
  logic [LCW-1:0]          lcnt_q, lcnt_d;
  logic [UCW-1:0]          ucnt_q, ucnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum;
  logic [1:0]              dec;
  logic                    apply;
  logic                    close;
  logic                    sym_q, sym_d;
  logic                    locked_q, locked_d;
  logic [1:0]              adj_q, adj_d;

  // Accumulator add with symmetric saturation at +/-(2^(ACC_W-1)-1)
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [WERR-1:0]  e);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W+1-WERR){e[WERR-1]}}, e};
    if (s > SMAX) s = SMAX;
    else if (s < SMIN) s = SMIN;
    return s[ACC_W-1:0];
  endfunction

  // Positive error means the strobe is early: retard; negative: advance
  function automatic logic [1:0] decide(input logic signed [ACC_W-1:0] s);
    if (s > TH_P) return ADJ_RET;
    else if (s < TH_N) return ADJ_ADV;
    else return ADJ_NONE;
  endfunction

  // Next-state: phase counter, window accumulation, decisions and lock FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    pend_d  = pend_q;
    lcnt_d  = lcnt_q;
    ucnt_d  = ucnt_q;
    acc_d   = acc_q;
    sum     = sat_add(acc_q, e_in_i);
    dec     = ADJ_NONE;
    apply   = 1'b0;
    close   = 1'b0;
    if (!en_i || state_q == IDLE) begin
      state_d = en_i ? ACQ : IDLE;
      cnt_d   = '0;
      win_d   = '0;
      pend_d  = ADJ_NONE;
      lcnt_d  = '0;
      ucnt_d  = '0;
      acc_d   = '0;
    end else begin
      apply = (cnt_q == '0) && (pend_q != ADJ_NONE);
      if (apply && pend_q == ADJ_RET)      cnt_d = '0;
      else if (apply && pend_q == ADJ_ADV) cnt_d = CW'(2);
      else if (cnt_q == CNT_LAST)          cnt_d = '0;
      else                                 cnt_d = cnt_q + CW'(1);
      if (apply) pend_d = ADJ_NONE;
      if (e_valid_i) begin
        close = (state_q == ACQ) || (win_q == WIN_LAST);
        if (close) begin
          dec   = decide(sum);
          acc_d = '0;
          win_d = '0;
          if (dec != ADJ_NONE) pend_d = dec;
          if (state_q == ACQ) begin
            ucnt_d = '0;
            if (dec != ADJ_NONE) lcnt_d = '0;
            else if (lcnt_q == LOCK_LAST) begin
              state_d = TRACK;
              lcnt_d  = '0;
            end else lcnt_d = lcnt_q + LCW'(1);
          end else begin
            lcnt_d = '0;
            if (dec == ADJ_NONE) ucnt_d = '0;
            else if (ucnt_q == UNLOCK_LAST) begin
              state_d = ACQ;
              ucnt_d  = '0;
            end else ucnt_d = ucnt_q + UCW'(1);
          end
        end else begin
          acc_d = sum;
          win_d = win_q + WINW'(1);
        end
      end
    end
    sym_d    = (state_d != IDLE) && (cnt_d == CNT_LAST);
    locked_d = (state_d == TRACK);
    adj_d    = ((state_d != IDLE) && (cnt_d == '0)) ? pend_d : ADJ_NONE;
  end

  // Control state and flop-driven outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_q    <= '0;
      pend_q   <= ADJ_NONE;
      lcnt_q   <= '0;
      ucnt_q   <= '0;
      sym_q    <= 1'b0;
      locked_q <= 1'b0;
      adj_q    <= ADJ_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      pend_q   <= pend_d;
      lcnt_q   <= lcnt_d;
      ucnt_q   <= ucnt_d;
      sym_q    <= sym_d;
      locked_q <= locked_d;
      adj_q    <= adj_d;
    end
  end

  // Error accumulator; held at zero by IDLE, so it needs no reset of its own
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign sym_valid_o = sym_q;
  assign locked_o    = locked_q;
  assign adj_o       = adj_q;

`ifdef SYMTIM_STATS_EN
  logic [15:0] adv_q, ret_q;

  // Saturating counts of applied adjustments; only reset clears them
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      adv_q <= '0;
      ret_q <= '0;
    end else if (apply) begin
      if (pend_q == ADJ_ADV && adv_q != 16'hFFFF) adv_q <= adv_q + 16'd1;
      if (pend_q == ADJ_RET && ret_q != 16'hFFFF) ret_q <= ret_q + 16'd1;
    end
  end

  assign adv_cnt_o = adv_q;
  assign ret_cnt_o = ret_q;
`else
  assign adv_cnt_o = '0;
  assign ret_cnt_o = '0;
`endif

endmodule

// File: tb/tb_symbol_timing_ctrl.sv
// Bench for symbol_timing_ctrl: a per-symbol reference model predicts each
// strobe interval, the adjust pulse inside it and the lock flag; a monitor
// process compares every strobe the DUT presents against the queued prediction.
module tb_symbol_timing_ctrl;
  localparam int OSF = 20, WERR = 18, ACC_W = 24, AVG_LOG2 = 3;
  localparam int THRESH = 1024, LOCK_CNT = 16, UNLOCK_CNT = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en_i = 1'b0;
  logic e_valid_i = 1'b0;
  logic signed [WERR-1:0] e_in_i = '0;
  logic sym_valid_o, locked_o;
  logic [1:0] adj_o;
  logic [15:0] adv_cnt_o, ret_cnt_o;

  always #5 clk = ~clk;

  symbol_timing_ctrl #(
    .OSF(OSF), .WERR(WERR), .ACC_W(ACC_W), .AVG_LOG2(AVG_LOG2),
    .THRESH(THRESH), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en_i(en_i), .e_in_i(e_in_i),
    .e_valid_i(e_valid_i), .sym_valid_o(sym_valid_o), .locked_o(locked_o),
    .adj_o(adj_o), .adv_cnt_o(adv_cnt_o), .ret_cnt_o(ret_cnt_o)
  );

  typedef struct {
    int         period;
    logic [1:0] adj;
    logic       locked;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0;
  int strobes = 0, served = 0;
  int exp_adv = 0, exp_ret = 0;

  // reference model state, one step per symbol
  int     m_track;
  longint m_sum;
  int     m_n, m_good, m_bad;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_track = 0; m_sum = 0; m_n = 0; m_good = 0; m_bad = 0;
  endfunction

  // One error in, one decision out: 2 = retard, 1 = advance, 0 = none
  function automatic int model_step(input int e);
    longint lim;
    int win_len;
    int d;
    lim = (64'sd1 <<< (ACC_W - 1)) - 1;
    m_sum = m_sum + e;
    if (m_sum > lim) m_sum = lim;
    if (m_sum < -lim) m_sum = -lim;
    m_n++;
    win_len = m_track ? (1 << AVG_LOG2) : 1;
    d = 0;
    if (m_n == win_len) begin
      if (m_sum > THRESH) d = 2;
      else if (m_sum < -THRESH) d = 1;
      m_sum = 0;
      m_n = 0;
      if (m_track == 0) begin
        if (d == 0) begin
          m_good++;
          if (m_good == LOCK_CNT) begin m_track = 1; m_good = 0; m_bad = 0; end
        end else m_good = 0;
      end else begin
        if (d != 0) begin
          m_bad++;
          if (m_bad == UNLOCK_CNT) begin m_track = 0; m_good = 0; m_bad = 0; end
        end else m_bad = 0;
      end
    end
    return d;
  endfunction

  // Monitor: samples 1 unit after each rising edge, compares on each strobe
  int gap = 0;
  logic [1:0] adj_seen = 2'b00;
  int adj_n = 0;
  exp_t cur;
  always begin
    @(posedge clk);
    #1;
    if (!reset_n || !en_i) begin
      chk("idle_sym", int'(sym_valid_o), 0);
      chk("idle_lock", int'(locked_o), 0);
      chk("idle_adj", int'(adj_o), 0);
      gap = 0; adj_seen = 2'b00; adj_n = 0;
    end else begin
      gap++;
      if (adj_o != 2'b00) begin adj_seen = adj_seen | adj_o; adj_n++; end
      if (gap == 1) begin
        if (sb.size() == 0) chk("lock_no_expect", 1, 0);
        else chk("locked", int'(locked_o), int'(sb[0].locked));
      end
      if (sym_valid_o) begin
        strobes++;
        if (sb.size() == 0) chk("strobe_no_expect", 1, 0);
        else begin
          cur = sb.pop_front();
          chk("period", gap, cur.period);
          chk("adj", int'(adj_seen), int'(cur.adj));
          chk("adj_pulses", adj_n, (cur.adj != 2'b00) ? 1 : 0);
        end
        gap = 0; adj_seen = 2'b00; adj_n = 0;
      end
    end
  end

  task automatic enable();
    @(negedge clk);
    en_i = 1'b1;
    model_reset();
    sb.push_back('{period: OSF, adj: 2'b00, locked: 1'b0});
  endtask

  // Serve n strobes as a combinational TED would; kind 0 = constant a,
  // kind 1 = uniform in [a,b]
  task automatic run_syms(input int n, input int kind, input int a, input int b);
    int done = 0, cyc = 0, budget, v, d;
    budget = n * (OSF + 2) + OSF + 10;
    while (done < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (sym_valid_o) begin
        v = (kind == 0) ? a : a + int'($urandom_range(0, b - a));
        e_in_i = WERR'(v);
        e_valid_i = 1'b1;
        d = model_step(v);
        if (d == 2) exp_ret++;
        if (d == 1) exp_adv++;
        sb.push_back('{period: OSF + ((d == 2) ? 1 : 0) - ((d == 1) ? 1 : 0),
                       adj: 2'(d), locked: (m_track != 0)});
        served++;
        done++;
      end else begin
        e_valid_i = 1'b0;
        e_in_i = WERR'($urandom);
      end
    end
    if (done < n) chk("strobe_timeout", done, n);
  endtask

  // Drop en_i mid-period (cnt near 7), hold it low, check the stats hold
  task automatic drop_en();
    repeat (8) begin
      @(negedge clk);
      e_valid_i = 1'b0;
    end
    en_i = 1'b0;
    sb.delete();
    repeat (4) @(negedge clk);
`ifdef SYMTIM_STATS_EN
    chk("adv_cnt", int'(adv_cnt_o), exp_adv);
    chk("ret_cnt", int'(ret_cnt_o), exp_ret);
`else
    chk("adv_cnt", int'(adv_cnt_o), 0);
    chk("ret_cnt", int'(ret_cnt_o), 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_adv", int'(adv_cnt_o), 0);
    chk("rst_ret", int'(ret_cnt_o), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // zero error: strobe every OSF cycles, lock after LOCK_CNT symbols
    enable();
    run_syms(20, 0, 0, 0);
    drop_en();

    // ACQ: constant large errors slip every period
    enable();
    run_syms(6, 0, 2000, 0);
    run_syms(6, 0, -2000, 0);
    run_syms(3, 0, 1025, 0);
    run_syms(3, 0, 1024, 0);
    run_syms(3, 0, -1025, 0);
    run_syms(3, 0, -1024, 0);
    drop_en();

    // lock, then averaged tracking behaviour and loss of lock
    enable();
    run_syms(16, 0, 0, 0);
    run_syms(16, 0, 200, 0);
    run_syms(16, 0, 100, 0);
    run_syms(32, 0, 5000, 0);
    run_syms(8, 1, -3000, 3000);
    drop_en();

    // random ACQ traffic, then random tracking traffic near the threshold
    enable();
    run_syms(30, 1, -3000, 3000);
    drop_en();
    enable();
    run_syms(16, 0, 0, 0);
    run_syms(64, 1, -400, 400);
    run_syms(16, 1, -131072, 131071);
    drop_en();

    chk("strobe_count", strobes, served);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/symbol_timing_ctrl.md
# symbol_timing_ctrl

Symbol-timing controller that closes the loop around the Gardner timing-error detector in the MSK receive path. It generates the once-per-symbol strobe that tells the TED when to compute an error. It accumulates the returned errors over a window and nudges the strobe phase by ±1 sample when the averaged error exceeds a threshold. An acquisition/tracking state machine selects the window length and reports lock.

## Interface
Parameters:
- OSF, 20, samples per symbol; nominal strobe period in clk cycles.
- WERR, 18, width of the signed error input.
- ACC_W, 24, width of the signed error accumulator.
- AVG_LOG2, 3, tracking window length is 2^AVG_LOG2 errors.
- THRESH, 1024, adjustment threshold; positive integer, compared against the window sum.
- LOCK_CNT, 16, consecutive no-adjust windows required to declare lock.
- UNLOCK_CNT, 4, consecutive adjust windows in TRACK that force loss of lock.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- en_i  in  1  loop enable; low forces IDLE.
- e_in_i  in  WERR signed  timing error from the TED.
- e_valid_i  in  1  error qualifier, one cycle per symbol.
- sym_valid_o  out  1  one-cycle symbol strobe to the TED.
- locked_o  out  1  high while in TRACK.
- adj_o  out  2  one-cycle pulse of the applied adjustment: 01 advance, 10 retard, 00 none.
- adv_cnt_o  out  16  saturating advance count (see Configuration).
- ret_cnt_o  out  16  saturating retard count (see Configuration).

## Operation
- The phase counter `cnt` runs 0..OSF-1 while `en_i` is high. `sym_valid_o` is high in every cycle where `cnt` == OSF-1 and the state is not IDLE.
- **States**
  - IDLE: counter, accumulator, window, lock and pending-adjust state are all held at zero.
  - ACQ: window length is 1 error.
  - TRACK: window length is 2^AVG_LOG2 errors.
- **Transitions**
  - IDLE→ACQ on `en_i`=1.
  - ACQ→TRACK after LOCK_CNT consecutive windows with no adjustment.
  - TRACK→ACQ after UNLOCK_CNT consecutive windows with an adjustment.
  - Any state→IDLE on `en_i`=0.
  - Each transition clears the accumulator, the window counter and the consecutive counters.
- **Accumulation**
  - `acc` += sign-extended `e_in_i` on each `e_valid_i`.
  - Saturates at ±(2^(ACC_W-1)-1).
  - `e_valid_i` is ignored in IDLE.
- **Window close** (the error that completes the window is included in the sum S):
  - S > THRESH: set pending retard.
  - S < -THRESH: set pending advance.
  - Otherwise: no adjustment.
  - In all three cases `acc` is cleared.
- **Applying a pending adjustment**
  - Applied on the next cycle in which `cnt` == 0.
  - Retard: `cnt` holds at 0 for one extra cycle, giving a period of OSF+1.
  - Advance: `cnt` steps 0→2, giving a period of OSF-1.
  - `adj_o` pulses in that cycle and the pending flag clears.
  - A new decision made while a pending adjustment is still outstanding overwrites it.
- **Coincident events**
  - `e_valid_i` coincides with `sym_valid_o` in normal use, because the TED is combinational.
  - A decision made on the wrap cycle (OSF-1→0) applies to the immediately following period.

## Timing
- **Reset values:**
  - `sym_valid_o`=0, `locked_o`=0, `adj_o`=00.
  - `adv_cnt_o`=0, `ret_cnt_o`=0.
  - `cnt`=0, state IDLE.
- **Start-up:** the first `sym_valid_o` occurs OSF cycles after the first cycle with `en_i`=1 sampled high.
- **Outputs:** all are flop-driven.
  - `locked_o` updates in the cycle after the window that completes the lock/unlock condition.
- **Decision latency:** the decision is registered one cycle after the closing `e_valid_i`.
- **Reset or disable mid-operation:**
  - `reset_n` or `en_i` low mid-window: all outputs return to their reset values the next cycle, except the stats counters, which are held on `en_i` low.
  - No partial strobe is issued.

## Configuration
- `SYMTIM_STATS_EN` defined:
  - `adv_cnt_o` / `ret_cnt_o` increment on each applied advance / retard.
  - Both saturate at 0xFFFF.
  - Both are cleared only by reset.
- Undefined: both ports are tied to 0 and the counter logic is not built.

## Test plan
- Reset, `en_i`=1, `e_in_i`=0 on every strobe:
  - First strobe at cycle 20, then every 20 cycles.
  - `locked_o` rises after the 16th strobe.
- In ACQ, `e_in_i`=+2000 on each strobe → every period is 21 cycles and `adj_o`=10 on each.
- In ACQ, `e_in_i`=-2000 → every period is 19 cycles and `adj_o`=01.
- Locked, `e_in_i`=+200 (S=1600) → one 21-cycle period per 8 symbols. With `e_in_i`=+100 (S=800) → no adjustment.
- Locked, `e_in_i`=+5000 for 32 symbols → `locked_o` falls after the 4th window and the state is ACQ.
- `en_i` dropped at `cnt`=7, re-raised 5 cycles later → no strobe while low, then the first strobe 20 cycles after re-enable. With `SYMTIM_STATS_EN`, `ret_cnt_o` retains its prior value.
